reg_file_scoreboard: RTL
========================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 3: address width; SHALL equal log2(DEPTH).
REQ-004 Parameter ZERO_REG, default 0: when 1, register 0 always reads 0, ignores writes and never becomes busy.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 write  input  1  write enable for wrAddr/wrData.
REQ-008 wrAddr  input  ADDR_W  write address.
REQ-009 wrData  input  WIDTH  write data.
REQ-010 rdAddrA  input  ADDR_W  read port A address.
REQ-011 rdDataA  output  WIDTH  read port A data, combinational.
REQ-012 rdAddrB  input  ADDR_W  read port B address.
REQ-013 rdDataB  output  WIDTH  read port B data, combinational.
REQ-014 reserve  input  1  marks rsvAddr as having a write in flight.
REQ-015 rsvAddr  input  ADDR_W  address to reserve.
REQ-016 busyA  output  1  the register at rdAddrA has a pending write (data is stale).
REQ-017 busyB  output  1  the register at rdAddrB has a pending write.
REQ-018 conflict  output  1  sticky, registered flag: a reservation was made to an already-busy register.

Function
REQ-019 Storage SHALL be DEPTH registers of WIDTH bits, with one busy bit per register.
REQ-020 Write: on a rising edge with write=1 and reset=0, regs[wrAddr] SHALL take wrData and busy[wrAddr] SHALL clear.
REQ-021 Bypass: when write=1 and wrAddr equals the read address, the read port SHALL output wrData in the same cycle; otherwise it SHALL output regs[rdAddr].
REQ-022 Busy bypass: busyX SHALL equal busy[rdAddrX] AND NOT (write AND wrAddr==rdAddrX).
REQ-023 Reserve: on a rising edge with reserve=1, busy[rsvAddr] SHALL be set.
REQ-024 A reservation SHALL NOT affect busyA/busyB until the following cycle.
REQ-025 Simultaneous write and reserve to the same address: data SHALL be written and busy SHALL end at 1, because the reservation wins.
REQ-026 Simultaneous write and reserve to different addresses: both SHALL take effect independently.
REQ-027 Reserving a register whose busy bit is already 1 and is not being cleared by a same-edge write SHALL set conflict to 1; busy stays 1.
REQ-028 conflict SHALL stay at 1 until reset.
REQ-029 With ZERO_REG=1, reads of address 0 SHALL return 0 (bypass included).
REQ-030 With ZERO_REG=1, writes and reservations to address 0 SHALL be ignored, busy[0] SHALL stay 0, and no conflict SHALL be raised.
REQ-031 Both read ports SHALL be independent and may use the same address.
REQ-032 Read latency SHALL be 0 cycles; write-to-read latency SHALL be 0 cycles through bypass and 1 cycle from storage.

Reset
REQ-033 With reset=1 on a rising edge, all registers SHALL become 0, all busy bits 0 and conflict 0.
REQ-034 Reset SHALL take priority over write and reserve on the same edge.
REQ-035 During the reset cycle, read outputs SHALL still follow REQ-021, so bypass stays active while reset=1.
REQ-036 Reset mid-operation SHALL discard all reservations, leaving no residual busy bits.

Verification
REQ-037 Pulse reset, then read all addresses -> rdDataA/B=0, busyA/B=0, conflict=0.
REQ-038 write=1, wrAddr=3, wrData=23, rdAddrA=3 in the same cycle -> rdDataA=23 before the edge; next cycle with write=0 -> rdDataA=23.
REQ-039 reserve rsvAddr=2; next cycle rdAddrB=2 -> busyB=1; then write wrAddr=2, wrData=31 -> busyB=0 and rdDataB=31 in that cycle; busy[2]=0 afterwards.
REQ-040 reserve 5 on two consecutive edges with no write -> conflict=1 after the second edge; it stays 1 over 4 idle cycles and clears only on reset.
REQ-041 Same edge: write wrAddr=4, wrData=45, reserve rsvAddr=4 -> afterwards regs[4]=45, busy for address 4 =1, conflict=0.
REQ-042 ZERO_REG=1, WIDTH=32, DEPTH=16: write addr 0 = 0xFFFF_FFFF plus reserve 0 -> rdDataA at address 0 reads 0, busyA=0, conflict=0; addr 15 write/read round-trips correctly.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy bits for tracking writes in flight.
// It has two combinational read ports with write bypass and a sticky flag for reserving an already-busy register.
module reg_file_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [WIDTH-1:0]  rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdDataB,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] rsvAddr,
  output logic              busyA,
  output logic              busyB,
  output logic              conflict
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;

  logic wr_en, rsv_en, rsv_cleared;
  logic hit_a, hit_b, zero_a, zero_b;

  // Register 0 is hard-wired when ZERO_REG is set, so its writes and reservations are dropped here.
  assign wr_en       = write   && !(ZERO_REG && (wrAddr  == '0));
  assign rsv_en      = reserve && !(ZERO_REG && (rsvAddr == '0));
  assign rsv_cleared = wr_en && (wrAddr == rsvAddr);

  assign hit_a  = write && (wrAddr == rdAddrA);
  assign hit_b  = write && (wrAddr == rdAddrB);
  assign zero_a = ZERO_REG && (rdAddrA == '0);
  assign zero_b = ZERO_REG && (rdAddrB == '0);

  assign rdDataA  = zero_a ? '0 : (hit_a ? wrData : regs_q[rdAddrA]);
  assign rdDataB  = zero_b ? '0 : (hit_b ? wrData : regs_q[rdAddrB]);
  assign busyA    = busy_q[rdAddrA] && !hit_a;
  assign busyB    = busy_q[rdAddrB] && !hit_b;
  assign conflict = conflict_q;

  // NOTE: combinational next-state uses blocking '=' with every output defaulted first,
  // so no latch is inferred and later statements can override earlier ones.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    conflict_d = conflict_q;
    if (wr_en) begin
      regs_d[wrAddr] = wrData;
      busy_d[wrAddr] = 1'b0;
    end
    // The reservation comes after the write so it wins on a same-address edge.
    if (rsv_en) begin
      if (busy_q[rsvAddr] && !rsv_cleared) conflict_d = 1'b1;
      busy_d[rsvAddr] = 1'b1;
    end
  end

  // NOTE: the storage array is reset explicitly because the register file must read 0 after reset.
  // A plain RAM macro would not be reset this way.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

endmodule
